// File: rtl/acc_2c_sat.sv
// acc_2c_sat: blocks of LEN signed samples summed with per-add overflow detect and optional saturation
module acc_2c_sat #(
  parameter int N = 4,
  parameter int LEN = 4,
  parameter bit SAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ov
);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  typedef enum logic {ACC, HOLD} state_t;
  state_t state, state_nx;
  logic [N-1:0] acc, sum, acc_nx;
  logic [CW-1:0] cnt;
  logic ov_sticky, ov, take, pop, last;
  assign take = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign last = cnt == CW'(LEN - 1);
  // acc and ov_sticky are cleared when a block closes, so a sample taken in HOLD already sees base 0
  assign sum = acc + in_data;
  assign ov = (acc[N-1] == in_data[N-1]) && (sum[N-1] != acc[N-1]);
  assign acc_nx = (SAT && ov) ? (in_data[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : sum;
  always_ff @(posedge clk)
    if (rst) state <= ACC;
    else state <= state_nx;
  always_comb state_nx = take ? (last ? HOLD : ACC) : (pop ? ACC : state);
  always_comb begin
    out_valid = state == HOLD;
    in_ready = (state == ACC) || out_ready;
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ov_sticky <= 1'b0;
      out_data <= '0;
      out_ov <= 1'b0;
    end else if (take) begin
      acc <= last ? '0 : acc_nx;
      ov_sticky <= last ? 1'b0 : (ov_sticky || ov);
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        out_data <= acc_nx;
        out_ov <= ov_sticky || ov;
      end
    end
endmodule

// File: tb/tb_acc_2c_sat.sv
// tb_acc_2c_sat: directed vectors against saturating and wrapping instances sharing one input stream
module tb_acc_2c_sat;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [3:0] in_data = '0;
  logic s_in_ready, s_out_valid, s_out_ov, w_in_ready, w_out_valid, w_out_ov;
  logic [3:0] s_out_data, w_out_data;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  acc_2c_sat #(.N(4), .LEN(4), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ov(s_out_ov));
  acc_2c_sat #(.N(4), .LEN(4), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .out_ov(w_out_ov));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input logic [3:0] d);
    in_valid = 1;
    in_data = d;
    tick();
    in_valid = 0;
  endtask
  task automatic feed4(input logic [3:0] a, b, c, d);
    feed(a);
    feed(b);
    feed(c);
    feed(d);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", s_out_valid, 0);
    chk("rst_data", s_out_data, 0);
    chk("rst_ov", s_out_ov, 0);
    chk("rst_ready", s_in_ready, 1);
    rst = 0;
    tick();
    feed(4'd1);
    feed(4'd3);
    feed(4'd2);
    chk("t1_mid_valid", s_out_valid, 0);
    feed(4'd1);
    chk("t1_valid", s_out_valid, 1);
    chk("t1_data", s_out_data, 4'h7);
    chk("t1_ov", s_out_ov, 0);
    chk("t1_wdata", w_out_data, 4'h7);
    tick();
    chk("t1_drain", s_out_valid, 0);
    feed4(4'h7, 4'h7, 4'hF, 4'h0);
    chk("t2_valid", s_out_valid, 1);
    chk("t2_data", s_out_data, 4'h6);
    chk("t2_ov", s_out_ov, 1);
    chk("t2_wdata", w_out_data, 4'hD);
    chk("t2_wov", w_out_ov, 1);
    tick();
    feed4(4'h8, 4'h8, 4'h8, 4'h1);
    chk("t3_data", s_out_data, 4'h9);
    chk("t3_ov", s_out_ov, 1);
    chk("t3_wdata", w_out_data, 4'h9);
    tick();
    feed4(4'h7, 4'h7, 4'h0, 4'h0);
    chk("t4_wdata", w_out_data, 4'hE);
    chk("t4_wov", w_out_ov, 1);
    chk("t4_sdata", s_out_data, 4'h7);
    tick();
    feed4(4'h1, 4'h1, 4'h1, 4'h1);
    out_ready = 0;
    in_valid = 1;
    in_data = 4'h3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", s_in_ready, 0);
      chk("bp_valid", s_out_valid, 1);
      chk("bp_data", s_out_data, 4'h4);
      tick();
    end
    out_ready = 1;
    #1;
    chk("bp_pass_ready", s_in_ready, 1);
    tick();
    in_valid = 0;
    chk("bp_popped", s_out_valid, 0);
    feed(4'h0);
    feed(4'h0);
    chk("bp_mid_valid", s_out_valid, 0);
    feed(4'h0);
    chk("bp_valid2", s_out_valid, 1);
    chk("bp_data2", s_out_data, 4'h3);
    chk("bp_ov2", s_out_ov, 0);
    tick();
    feed(4'h5);
    feed(4'h5);
    rst = 1;
    tick();
    rst = 0;
    chk("mr_valid", s_out_valid, 0);
    feed(4'h1);
    feed(4'h1);
    feed(4'h1);
    chk("mr_no_early", s_out_valid, 0);
    feed(4'h1);
    chk("mr_valid2", s_out_valid, 1);
    chk("mr_data", s_out_data, 4'h4);
    chk("mr_ov", s_out_ov, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
